// File: rtl/spi_word_controller.sv
// SPI mode-0 initiator for little-endian words: one CS-low frame per word, with the reply
// captured from CIPO during the same frame.
module spi_word_controller #(
    parameter int unsigned WORD_BITS = 64,
    parameter int unsigned CLK_DIV   = 4,
    parameter int unsigned CS_SETUP  = 2,
    parameter int unsigned CS_HOLD   = 2,
    parameter int unsigned CS_GAP    = 4
) (
    input  logic                 CLK,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WORD_BITS-1:0] tx_word,
    output logic                 busy,
    output logic                 done,
    output logic [WORD_BITS-1:0] rx_word,
    output logic                 SCK,
    output logic                 CS,
    output logic                 COPI,
    input  logic                 CIPO
);

    localparam int unsigned BitW    = $clog2(WORD_BITS);
    localparam int unsigned HalfW   = $clog2(CLK_DIV + 1);
    localparam int unsigned WaitMax = (CS_SETUP > CS_HOLD) ?
                                      ((CS_SETUP > CS_GAP) ? CS_SETUP : CS_GAP) :
                                      ((CS_HOLD > CS_GAP) ? CS_HOLD : CS_GAP);
    localparam int unsigned WaitW   = $clog2(WaitMax + 1);

    localparam logic [BitW-1:0]  LastBit    = BitW'(WORD_BITS - 1);
    localparam logic [HalfW-1:0] HalfReload = HalfW'(CLK_DIV - 1);

    typedef enum logic [2:0] {StIdle, StSetup, StShift, StHold, StGap} state_e;

    // Frame bit n lives at word bit 8*(n/8) + 7 - n%8: bytes ascending, MSB first.
    function automatic logic [BitW-1:0] frame_pos(input logic [BitW-1:0] n);
        return n ^ BitW'(7);
    endfunction

    state_e               state_q, state_d;
    logic [WaitW-1:0]     wait_q, wait_d;
    logic [HalfW-1:0]     half_q, half_d;
    logic [BitW-1:0]      bit_q, bit_d;
    logic [BitW-1:0]      next_bit;
    logic                 sck_q, sck_d;
    logic                 cs_q, cs_d;
    logic                 copi_q, copi_d;
    logic                 done_q, done_d;
    logic [WORD_BITS-1:0] shift_tx_q, shift_tx_d;
    logic [WORD_BITS-1:0] shift_rx_q, shift_rx_d;
    logic [WORD_BITS-1:0] rx_word_q, rx_word_d;

    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        half_d     = half_q;
        bit_d      = bit_q;
        sck_d      = sck_q;
        cs_d       = cs_q;
        copi_d     = copi_q;
        done_d     = 1'b0;
        shift_tx_d = shift_tx_q;
        shift_rx_d = shift_rx_q;
        rx_word_d  = rx_word_q;
        next_bit   = bit_q + 1'b1;

        unique case (state_q)
            StIdle: begin
                sck_d = 1'b0;
                cs_d  = 1'b1;
                if (start) begin
                    shift_tx_d = tx_word;
                    bit_d      = '0;
                    cs_d       = 1'b0;
                    copi_d     = tx_word[frame_pos('0)];
                    wait_d     = WaitW'(CS_SETUP - 1);
                    state_d    = StSetup;
                end
            end
            StSetup: begin
                if (wait_q == '0) begin
                    sck_d                       = 1'b1;
                    half_d                      = HalfReload;
                    shift_rx_d[frame_pos(bit_q)] = CIPO;
                    state_d                     = StShift;
                end else begin
                    wait_d = wait_q - 1'b1;
                end
            end
            StShift: begin
                if (half_q != '0) begin
                    half_d = half_q - 1'b1;
                end else if (sck_q) begin
                    // Falling edge: present the next bit for a full low half-period.
                    sck_d  = 1'b0;
                    half_d = HalfReload;
                    if (bit_q != LastBit) begin
                        copi_d = shift_tx_q[frame_pos(next_bit)];
                    end
                end else if (bit_q == LastBit) begin
                    wait_d  = WaitW'(CS_HOLD - 1);
                    state_d = StHold;
                end else begin
                    bit_d                           = next_bit;
                    sck_d                           = 1'b1;
                    half_d                          = HalfReload;
                    shift_rx_d[frame_pos(next_bit)] = CIPO;
                end
            end
            StHold: begin
                if (wait_q == '0) begin
                    cs_d      = 1'b1;
                    done_d    = 1'b1;
                    rx_word_d = shift_rx_q;
                    wait_d    = WaitW'(CS_GAP - 1);
                    state_d   = StGap;
                end else begin
                    wait_d = wait_q - 1'b1;
                end
            end
            StGap: begin
                if (wait_q == '0) begin
                    state_d = StIdle;
                end else begin
                    wait_d = wait_q - 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                sck_d   = 1'b0;
                cs_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            wait_q     <= '0;
            half_q     <= '0;
            bit_q      <= '0;
            sck_q      <= 1'b0;
            cs_q       <= 1'b1;
            copi_q     <= 1'b0;
            done_q     <= 1'b0;
            shift_tx_q <= '0;
            shift_rx_q <= '0;
            rx_word_q  <= '0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            half_q     <= half_d;
            bit_q      <= bit_d;
            sck_q      <= sck_d;
            cs_q       <= cs_d;
            copi_q     <= copi_d;
            done_q     <= done_d;
            shift_tx_q <= shift_tx_d;
            shift_rx_q <= shift_rx_d;
            rx_word_q  <= rx_word_d;
        end
    end

    assign busy    = (state_q != StIdle);
    assign done    = done_q;
    assign rx_word = rx_word_q;
    assign SCK     = sck_q;
    assign CS      = cs_q;
    assign COPI    = copi_q;

endmodule

// File: tb/tb_spi_word_controller.sv
// Directed bench for spi_word_controller: loopback and a mode-0 peripheral model on CIPO.
module tb_spi_word_controller;

    logic        CLK;
    logic        reset;
    logic        start;
    logic [63:0] tx_word;
    logic        busy;
    logic        done;
    logic [63:0] rx_word;
    logic        SCK;
    logic        CS;
    logic        COPI;
    logic        CIPO;

    int total;
    int bad;

    logic        loopback;
    logic [63:0] reply;

    spi_word_controller dut (
        .CLK     (CLK),
        .reset   (reset),
        .start   (start),
        .tx_word (tx_word),
        .busy    (busy),
        .done    (done),
        .rx_word (rx_word),
        .SCK     (SCK),
        .CS      (CS),
        .COPI    (COPI),
        .CIPO    (CIPO)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Frame monitor: rises per frame, COPI at each rise, peripheral-side received word.
    int          rises;
    int          frame_id;
    int          bad_rises;
    logic [63:0] copi_bits;
    logic [63:0] prx;
    logic [5:0]  ridx;
    initial begin
        rises = 0; frame_id = 0; bad_rises = 0; copi_bits = '0; prx = '0;
    end
    always @(negedge CS or posedge SCK) begin
        if (SCK === 1'b1) begin
            if (CS !== 1'b0) bad_rises++;
            ridx = rises[5:0];
            if (rises < 64) begin
                copi_bits[ridx] = COPI;
                prx[ridx ^ 6'd7] = COPI;
            end
            rises++;
        end else begin
            rises = 0;
            frame_id++;
        end
    end

    // Peripheral shifts its next reply bit out on each SCK fall.
    int snap_rises;
    int snap_frame;
    initial begin
        snap_rises = 0; snap_frame = -1;
    end
    always @(negedge SCK) begin
        snap_rises = rises;
        snap_frame = frame_id;
    end

    logic [5:0] pidx;
    logic       cipo_periph;
    always_comb begin
        pidx        = (snap_frame == frame_id) ? snap_rises[5:0] : 6'd0;
        cipo_periph = reply[pidx ^ 6'd7];
    end
    assign CIPO = loopback ? COPI : cipo_periph;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 100) begin
            tick();
            n++;
        end
        if (busy !== 1'b0) begin
            total++; bad++;
            $display("FAIL wait_idle: busy=%b required 0", busy);
        end
    endtask

    task automatic run_frame(input logic [63:0] tx, output int lat, output int cs_low);
        tx_word = tx;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        lat     = 1;
        cs_low  = (CS === 1'b0) ? 1 : 0;
        while (done !== 1'b1 && lat < 2000) begin
            tick();
            lat++;
            if (CS === 1'b0) cs_low++;
        end
        if (done !== 1'b1) begin
            total++; bad++;
            $display("FAIL frame_timeout: no done after %0d cycles", lat);
        end
    endtask

    task automatic test_reset();
        int dones;
        reset = 1'b1; start = 1'b0; tx_word = '0; loopback = 1'b1; reply = '0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        total++; if (CS !== 1'b1)      begin bad++; $display("FAIL reset_cs: got %b want 1", CS); end
        total++; if (SCK !== 1'b0)     begin bad++; $display("FAIL reset_sck: got %b want 0", SCK); end
        total++; if (COPI !== 1'b0)    begin bad++; $display("FAIL reset_copi: got %b want 0", COPI); end
        total++; if (busy !== 1'b0)    begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0)    begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        total++; if (rx_word !== '0)   begin bad++; $display("FAIL reset_rx: got %h want 0", rx_word); end

        tx_word = 64'hFFFF_FFFF_FFFF_FFFF;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        repeat (100) tick();
        total++; if (CS !== 1'b0)      begin bad++; $display("FAIL midframe_cs: got %b want 0", CS); end
        #2 reset = 1'b1;
        #1;
        total++; if (CS !== 1'b1)      begin bad++; $display("FAIL async_cs: got %b want 1", CS); end
        total++; if (SCK !== 1'b0)     begin bad++; $display("FAIL async_sck: got %b want 0", SCK); end
        total++; if (busy !== 1'b0)    begin bad++; $display("FAIL async_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0)    begin bad++; $display("FAIL async_done: got %b want 0", done); end
        total++; if (rx_word !== '0)   begin bad++; $display("FAIL async_rx: got %h want 0", rx_word); end
        tick();
        reset = 1'b0;
        dones = 0;
        repeat (700) begin
            tick();
            if (done === 1'b1) dones++;
        end
        total++; if (dones != 0)       begin bad++; $display("FAIL partial_done: got %0d want 0", dones); end
    endtask

    task automatic test_loopback();
        int lat;
        int cs_low;
        loopback = 1'b1;
        run_frame(64'h0123_4567_89AB_CDEF, lat, cs_low);
        total++; if (lat != 517)       begin bad++; $display("FAIL lb_latency: got %0d want 517", lat); end
        total++; if (cs_low != 516)    begin bad++; $display("FAIL lb_cs_low: got %0d want 516", cs_low); end
        total++; if (rx_word !== 64'h0123_4567_89AB_CDEF)
            begin bad++; $display("FAIL lb_rx: got %h want 0123456789abcdef", rx_word); end
        total++; if (rises != 64)      begin bad++; $display("FAIL lb_rises: got %0d want 64", rises); end
        tick();
        total++; if (done !== 1'b0)    begin bad++; $display("FAIL lb_done_pulse: got %b want 0", done); end
        wait_idle();
    endtask

    task automatic test_bit_order();
        int lat;
        int cs_low;
        loopback = 1'b1;
        run_frame(64'h0000_0000_0000_0080, lat, cs_low);
        total++; if (copi_bits !== 64'h0000_0000_0000_0001)
            begin bad++; $display("FAIL order_first: got %h want 0000000000000001", copi_bits); end
        total++; if (rx_word !== 64'h0000_0000_0000_0080)
            begin bad++; $display("FAIL order_first_rx: got %h want 0000000000000080", rx_word); end
        wait_idle();
        run_frame(64'h0100_0000_0000_0000, lat, cs_low);
        total++; if (copi_bits !== 64'h8000_0000_0000_0000)
            begin bad++; $display("FAIL order_last: got %h want 8000000000000000", copi_bits); end
        total++; if (rx_word !== 64'h0100_0000_0000_0000)
            begin bad++; $display("FAIL order_last_rx: got %h want 0100000000000000", rx_word); end
        wait_idle();
    endtask

    task automatic test_peripheral();
        int lat;
        int cs_low;
        loopback = 1'b0;
        reply    = 64'hDEAD_BEEF_CAFE_F00D;
        run_frame(64'h1122_3344_5566_7788, lat, cs_low);
        total++; if (rx_word !== 64'hDEAD_BEEF_CAFE_F00D)
            begin bad++; $display("FAIL periph_rx: got %h want deadbeefcafef00d", rx_word); end
        total++; if (prx !== 64'h1122_3344_5566_7788)
            begin bad++; $display("FAIL periph_received: got %h want 1122334455667788", prx); end
        tick();
        total++; if (done !== 1'b0)    begin bad++; $display("FAIL periph_done_pulse: got %b want 0", done); end
        wait_idle();
        repeat (20) tick();
        total++; if (rx_word !== 64'hDEAD_BEEF_CAFE_F00D)
            begin bad++; $display("FAIL periph_rx_stable: got %h want deadbeefcafef00d", rx_word); end
        loopback = 1'b1;
    endtask

    task automatic test_back_to_back();
        int   dones;
        int   falls;
        int   run;
        int   min_gap;
        int   cyc;
        int   done_cyc[3];
        logic cs_prev;
        loopback = 1'b1;
        tx_word  = 64'hA5A5_5A5A_0F0F_F0F0;
        dones = 0; falls = 0; run = 0; min_gap = 1000; cyc = 0;
        cs_prev = CS;
        start = 1'b1;
        while (dones < 3 && cyc < 3000) begin
            tick();
            cyc++;
            if (done === 1'b1) begin
                done_cyc[dones] = cyc;
                dones++;
            end
            if (CS === 1'b1) begin
                run++;
            end else begin
                if (cs_prev === 1'b1) begin
                    falls++;
                    if (dones > 0 && run < min_gap) min_gap = run;
                    if (falls == 3) start = 1'b0;
                end
                run = 0;
            end
            cs_prev = CS;
        end
        start = 1'b0;
        total++; if (dones != 3)       begin bad++; $display("FAIL b2b_dones: got %0d want 3", dones); end
        total++; if (min_gap != 5)     begin bad++; $display("FAIL b2b_cs_gap: got %0d want 5", min_gap); end
        if (dones == 3) begin
            total++;
            if (done_cyc[1] - done_cyc[0] != 521) begin
                bad++;
                $display("FAIL b2b_period: got %0d want 521", done_cyc[1] - done_cyc[0]);
            end
        end
        repeat (700) begin
            tick();
            if (done === 1'b1) dones++;
        end
        total++; if (dones != 3)       begin bad++; $display("FAIL b2b_extra: got %0d want 3", dones); end
        total++; if (rx_word !== 64'hA5A5_5A5A_0F0F_F0F0)
            begin bad++; $display("FAIL b2b_rx: got %h want a5a55a5a0f0ff0f0", rx_word); end
    endtask

    task automatic test_busy_ignore();
        int dones;
        loopback = 1'b1;
        tx_word  = 64'h0000_0000_0000_0001;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        dones    = 0;
        for (int i = 0; i < 300; i++) begin
            start = (busy === 1'b1) && (i % 2 == 0);
            tick();
            if (done === 1'b1) dones++;
        end
        start = 1'b0;
        repeat (1200) begin
            tick();
            if (done === 1'b1) dones++;
        end
        total++; if (dones != 1)       begin bad++; $display("FAIL busy_ignore: got %0d dones want 1", dones); end
        total++; if (busy !== 1'b0)    begin bad++; $display("FAIL busy_final: got %b want 0", busy); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_loopback();
        test_bit_order();
        test_peripheral();
        test_back_to_back();
        test_busy_ignore();
        total++; if (bad_rises != 0)   begin bad++; $display("FAIL sck_cs_high: got %0d want 0", bad_rises); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
